// File: rtl/jtframe_romarb_pkg.sv
// Shared definitions for the ROM arbiter: FSM encoding, the address-to-line
// shift for a given slot width, and the rotating priority picker.
package jtframe_romarb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    // Number of slot address bits that select a lane inside one 32-bit line.
    function automatic int line_shift(input int dw);
        int s;
        if (dw == 32'sd8) begin
            s = 32'sd2;
        end else if (dw == 32'sd16) begin
            s = 32'sd1;
        end else begin
            s = 32'sd0;
        end
        return s;
    endfunction

    // First set bit of mask at or after ptr, wrapping modulo slots.
    // With ptr = 0 this degenerates to lowest-index-wins.
    function automatic logic [3:0] rr_pick(input logic [15:0] mask,
                                           input logic [3:0]  ptr,
                                           input logic [4:0]  slots);
        logic [3:0] pick;
        logic       found;
        logic [4:0] idx;
        pick  = 4'd0;
        found = 1'b0;
        for (int k = 0; k < 16; k++) begin
            idx = {1'b0, ptr} + 5'(k);
            if (idx >= slots) begin
                idx = idx - slots;
            end else begin
                idx = idx;
            end
            if (!found && (5'(k) < slots) && mask[idx[3:0]]) begin
                pick  = idx[3:0];
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/jtframe_romarb_slot.sv
// One-line 32-bit cache for a single ROM slot: tag/valid/data storage,
// hit compare and lane selection towards the slot consumer.
module jtframe_romarb_slot
    import jtframe_romarb_pkg::*;
#(
    parameter int SLOT_AW = 20,
    parameter int DW      = 8,
    parameter int LW      = 18
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic [SLOT_AW-1:0] addr,
    input  logic               cs,
    input  logic               we,
    input  logic [LW-1:0]      wr_tag,
    input  logic [31:0]        wr_data,
    output logic [LW-1:0]      line,
    output logic [DW-1:0]      dout,
    output logic               hit,
    output logic               ok
);

    localparam int SH = line_shift(DW);

    logic          valid_r;
    logic [LW-1:0] tag_r;
    logic [31:0]   data_r;

    assign line = addr[SLOT_AW-1:SH];
    assign hit  = valid_r & (tag_r == line);
    assign ok   = cs & hit;

    // Cache line storage; flush beats a simultaneous fill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            tag_r   <= '0;
            data_r  <= 32'd0;
        end else if (flush) begin
            valid_r <= 1'b0;
        end else if (we) begin
            valid_r <= 1'b1;
            tag_r   <= wr_tag;
            data_r  <= wr_data;
        end
    end

    if (DW == 8) begin : g_lane8
        // Byte lane select, lane 0 is the lowest byte.
        always_comb begin
            case (addr[1:0])
                2'd0:    dout = data_r[7:0];
                2'd1:    dout = data_r[15:8];
                2'd2:    dout = data_r[23:16];
                2'd3:    dout = data_r[31:24];
                default: dout = data_r[7:0];
            endcase
        end
    end else if (DW == 16) begin : g_lane16
        // Halfword lane select, lower address in the low half.
        always_comb begin
            if (addr[0]) begin
                dout = data_r[31:16];
            end else begin
                dout = data_r[15:0];
            end
        end
    end else begin : g_lane32
        assign dout = data_r;
    end

endmodule

// File: rtl/jtframe_romarb.sv
// SDRAM read-only arbiter for N cached ROM slots. Misses are granted one at
// a time onto a single read port; the FSM re-arbitrates in the data cycle so
// consecutive fetches run without an idle gap.
module jtframe_romarb
    import jtframe_romarb_pkg::*;
#(
    parameter int SLOTS   = 4,
    parameter int SLOT_AW = 20,
    parameter int DW      = 8,
    parameter int AW      = 22,
    parameter int RR      = 0,
    parameter logic [SLOTS*AW-1:0] OFFSETS = '0
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     vblank,
    input  logic                     flush,
    input  logic [SLOTS*SLOT_AW-1:0] slot_addr,
    input  logic [SLOTS-1:0]         slot_cs,
    output logic [SLOTS*DW-1:0]      slot_dout,
    output logic [SLOTS-1:0]         slot_ok,
    output logic                     sdram_req,
    input  logic                     sdram_ack,
    output logic [AW-1:0]            sdram_addr,
    input  logic                     data_rdy,
    input  logic [31:0]              data_read,
    output logic                     refresh_en,
    output logic                     ready
);

    localparam int         LW     = SLOT_AW - line_shift(DW);
    localparam logic [4:0] NSLOTS = 5'(SLOTS);
    localparam logic [3:0] LAST   = 4'(SLOTS - 1);

    logic [1:0]    state_r, state_n;
    logic          req_r, req_n;
    logic [AW-1:0] addr_r, addr_n;
    logic [3:0]    grant_r, grant_n;
    logic [LW-1:0] tag_r, tag_n;
    logic [3:0]    ptr_r, ptr_n;
    logic          discard_r, discard_n;
    logic          refresh_r;
    logic [3:0]    rdy_sr_r;

    logic [SLOTS-1:0] hit_s, own_s, miss_s, we_s;
    logic [LW-1:0]    line_s [SLOTS];
    logic [AW-1:0]    cand_addr_s [SLOTS];
    logic [15:0]      miss16_s;
    logic [3:0]       pick_s;
    logic [LW-1:0]    pick_line_s;
    logic [AW-1:0]    pick_addr_s;
    logic             busy_s, any_miss_s, done_s, issue_s;

    for (genvar i = 0; i < SLOTS; i++) begin : g_slot
        jtframe_romarb_slot #(
            .SLOT_AW (SLOT_AW),
            .DW      (DW),
            .LW      (LW)
        ) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .flush   (flush),
            .addr    (slot_addr[i*SLOT_AW +: SLOT_AW]),
            .cs      (slot_cs[i]),
            .we      (we_s[i]),
            .wr_tag  (tag_r),
            .wr_data (data_read),
            .line    (line_s[i]),
            .dout    (slot_dout[i*DW +: DW]),
            .hit     (hit_s[i]),
            .ok      (slot_ok[i])
        );
        assign cand_addr_s[i] = OFFSETS[i*AW +: AW] + AW'({line_s[i], 1'b0});
    end

    assign busy_s     = (state_r != ST_IDLE);
    assign done_s     = data_rdy & ((state_r == ST_DATA) | ((state_r == ST_WAIT) & sdram_ack));
    assign miss_s     = slot_cs & ~hit_s & ~own_s;
    assign any_miss_s = |miss_s;
    assign issue_s    = any_miss_s & ((state_r == ST_IDLE) | done_s);
    assign miss16_s   = 16'(miss_s);
    assign pick_s     = rr_pick(miss16_s, (RR != 32'sd0) ? ptr_r : 4'd0, NSLOTS);

    // In-flight slot mask and fill write strobes; a discarded or flushed fill never writes.
    always_comb begin
        own_s = '0;
        we_s  = '0;
        for (int i = 0; i < SLOTS; i++) begin
            own_s[i] = busy_s & (grant_r == 4'(i));
            we_s[i]  = done_s & ~discard_r & ~flush & (grant_r == 4'(i));
        end
    end

    // Line and SDRAM address of the arbitration winner.
    always_comb begin
        pick_line_s = line_s[0];
        pick_addr_s = cand_addr_s[0];
        for (int i = 1; i < SLOTS; i++) begin
            pick_line_s = (pick_s == 4'(i)) ? line_s[i]      : pick_line_s;
            pick_addr_s = (pick_s == 4'(i)) ? cand_addr_s[i] : pick_addr_s;
        end
    end

    // Request FSM next state: issue on a miss, drop req on ack, finish on data.
    always_comb begin
        state_n   = state_r;
        req_n     = req_r;
        addr_n    = addr_r;
        grant_n   = grant_r;
        tag_n     = tag_r;
        ptr_n     = ptr_r;
        discard_n = discard_r | (busy_s & flush);
        if (issue_s) begin
            state_n   = ST_WAIT;
            req_n     = 1'b1;
            addr_n    = pick_addr_s;
            grant_n   = pick_s;
            tag_n     = pick_line_s;
            discard_n = 1'b0;
            ptr_n     = (RR != 32'sd0) ? ((pick_s == LAST) ? 4'd0 : pick_s + 4'd1) : ptr_r;
        end else if (done_s) begin
            state_n = ST_IDLE;
            req_n   = 1'b0;
        end else if ((state_r == ST_WAIT) && sdram_ack) begin
            state_n = ST_DATA;
            req_n   = 1'b0;
        end else if ((state_r == ST_IDLE) || (state_r == ST_WAIT) || (state_r == ST_DATA)) begin
            state_n = state_r;
        end else begin
            state_n = ST_IDLE;
            req_n   = 1'b0;
        end
    end

    // FSM and request registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            req_r     <= 1'b0;
            addr_r    <= '0;
            grant_r   <= 4'd0;
            tag_r     <= '0;
            ptr_r     <= 4'd0;
            discard_r <= 1'b0;
        end else begin
            state_r   <= state_n;
            req_r     <= req_n;
            addr_r    <= addr_n;
            grant_r   <= grant_n;
            tag_r     <= tag_n;
            ptr_r     <= ptr_n;
            discard_r <= discard_n;
        end
    end

    // Refresh permitted only while idle, with no pending miss, during vblank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_r <= 1'b1;
        end else begin
            refresh_r <= (state_r == ST_IDLE) & ~any_miss_s & vblank;
        end
    end

    // Ready rises after four clocks out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_sr_r <= 4'd0;
        end else begin
            rdy_sr_r <= {rdy_sr_r[2:0], 1'b1};
        end
    end

    assign sdram_req  = req_r;
    assign sdram_addr = addr_r;
    assign refresh_en = refresh_r;
    assign ready      = rdy_sr_r[3];

endmodule

// File: tb/tb_jtframe_romarb.sv
// Bench for jtframe_romarb: a fixed-priority instance and a round-robin
// instance, checked against a slot-cache / SDRAM model kept in the bench.
module tb_jtframe_romarb;

    localparam int SLOTS = 4, SLOT_AW = 20, DW = 8, AW = 22;
    localparam logic [SLOTS*AW-1:0] OFFS = {22'h30000, 22'h20000, 22'h10000, 22'h00000};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, vblank, flush;
    // fixed-priority instance
    logic [SLOTS*SLOT_AW-1:0] slot_addr;
    logic [SLOTS-1:0]         slot_cs, slot_ok;
    logic [SLOTS*DW-1:0]      slot_dout;
    logic sdram_req, sdram_ack, data_rdy, refresh_en, ready;
    logic [AW-1:0] sdram_addr;
    logic [31:0]   data_read;
    // round-robin instance
    logic [SLOTS*SLOT_AW-1:0] addr2;
    logic [SLOTS-1:0]         cs2, ok2;
    logic [SLOTS*DW-1:0]      dout2;
    logic req2, ack2, rdy2, refresh2, ready2;
    logic [AW-1:0] saddr2;
    logic [31:0]   dread2;

    int checks = 0;
    int fails  = 0;
    logic        mvalid [SLOTS];
    logic [17:0] mline  [SLOTS];

    jtframe_romarb #(.SLOTS(SLOTS), .SLOT_AW(SLOT_AW), .DW(DW), .AW(AW), .RR(0), .OFFSETS(OFFS)) u_fp (
        .clk(clk), .rst_n(rst_n), .vblank(vblank), .flush(flush),
        .slot_addr(slot_addr), .slot_cs(slot_cs), .slot_dout(slot_dout), .slot_ok(slot_ok),
        .sdram_req(sdram_req), .sdram_ack(sdram_ack), .sdram_addr(sdram_addr),
        .data_rdy(data_rdy), .data_read(data_read), .refresh_en(refresh_en), .ready(ready));

    jtframe_romarb #(.SLOTS(SLOTS), .SLOT_AW(SLOT_AW), .DW(DW), .AW(AW), .RR(1), .OFFSETS(OFFS)) u_rr (
        .clk(clk), .rst_n(rst_n), .vblank(vblank), .flush(flush),
        .slot_addr(addr2), .slot_cs(cs2), .slot_dout(dout2), .slot_ok(ok2),
        .sdram_req(req2), .sdram_ack(ack2), .sdram_addr(saddr2),
        .data_rdy(rdy2), .data_read(dread2), .refresh_en(refresh2), .ready(ready2));

    // ---------------- reference model ----------------
    function automatic logic [15:0] h16(input logic [21:0] a);
        return a[15:0] ^ {a[21:16], 10'h2B5} ^ 16'h9E37;
    endfunction

    function automatic logic [31:0] mem_word(input logic [21:0] a);
        return {h16(a + 22'd1), h16(a)};
    endfunction

    // slot base is s * 0x10000; one 32-bit line = 4 bytes = 2 SDRAM words
    function automatic logic [21:0] exp_addr(input int s, input logic [19:0] a);
        return 22'(s * 32'h10000 + 2 * (int'(a) / 4));
    endfunction

    function automatic logic [7:0] exp_byte(input int s, input logic [19:0] a);
        logic [31:0] w;
        w = mem_word(exp_addr(s, a)) >> (8 * (int'(a) % 4));
        return w[7:0];
    endfunction

    function automatic logic [19:0] rand_addr();
        return 20'($urandom_range(0, 32767));
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int s = 0; s < SLOTS; s++) mvalid[s] = 1'b0;
    endtask

    // SDRAM responder for the fixed-priority instance; reports what it saw.
    task automatic serve1(input logic do_flush, output logic [21:0] got_addr,
                          output logic got, output int waited);
        int n;
        n = 0;
        while (!sdram_req && n < 20) begin
            tick();
            n++;
        end
        waited   = n;
        got      = sdram_req;
        got_addr = sdram_addr;
        if (got) begin
            repeat ($urandom_range(0, 2)) tick();
            sdram_ack = 1'b1;
            if ($urandom_range(0, 3) == 0) begin
                data_rdy  = 1'b1;
                data_read = mem_word(got_addr);
                flush     = do_flush;
                tick();
                sdram_ack = 1'b0;
            end else begin
                tick();
                sdram_ack = 1'b0;
                repeat ($urandom_range(0, 2)) tick();
                data_rdy  = 1'b1;
                data_read = mem_word(got_addr);
                flush     = do_flush;
                tick();
            end
            data_rdy  = 1'b0;
            flush     = 1'b0;
            data_read = $urandom;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; vblank = 1'b0; flush = 1'b0;
        slot_addr = '0; slot_cs = '0; sdram_ack = 1'b0; data_rdy = 1'b0; data_read = 32'd0;
        addr2 = '0; cs2 = '0; ack2 = 1'b0; rdy2 = 1'b0; dread2 = 32'd0;
        repeat (3) tick();
        checks++; if ({refresh_en, refresh2} !== 2'b11) begin fails++; $display("FAIL reset_refresh got=%b exp=11", {refresh_en, refresh2}); end
        checks++; if ({ready, ready2, sdram_req, req2} !== 4'b0000) begin fails++; $display("FAIL reset_ctrl got=%b exp=0000", {ready, ready2, sdram_req, req2}); end
        checks++; if (sdram_addr !== 22'd0) begin fails++; $display("FAIL reset_addr got=%h exp=0", sdram_addr); end
        checks++; if ({slot_ok, slot_dout, dout2} !== 68'd0) begin fails++; $display("FAIL reset_slots got=%h exp=0", {slot_ok, slot_dout, dout2}); end
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++; if (ready !== (k >= 4)) begin fails++; $display("FAIL ready_cycle%0d got=%b exp=%b", k, ready, (k >= 4)); end
        end
    endtask

    task automatic test_fill();
        logic stray;
        slot_addr[1*SLOT_AW +: SLOT_AW] = 20'h00007;
        slot_cs = 4'b0010;
        tick();
        checks++; if (sdram_req !== 1'b1 || sdram_addr !== 22'h10002) begin fails++; $display("FAIL fill_req got=%b/%h exp=1/10002", sdram_req, sdram_addr); end
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        checks++; if (sdram_req !== 1'b0 || slot_ok[1] !== 1'b0) begin fails++; $display("FAIL fill_ack got=%b/%b exp=0/0", sdram_req, slot_ok[1]); end
        data_rdy = 1'b1; data_read = 32'hDDCCBBAA;
        tick();
        data_rdy = 1'b0;
        checks++; if (slot_ok[1] !== 1'b1 || slot_dout[15:8] !== 8'hDD) begin fails++; $display("FAIL fill_ok got=%b/%h exp=1/dd", slot_ok[1], slot_dout[15:8]); end
        slot_addr[1*SLOT_AW +: SLOT_AW] = 20'h00004;
        stray = 1'b0;
        repeat (4) begin
            tick();
            stray = stray | sdram_req;
        end
        checks++; if (slot_ok[1] !== 1'b1 || slot_dout[15:8] !== 8'hAA || stray !== 1'b0) begin fails++; $display("FAIL fill_hit got=%b/%h/%b exp=1/aa/0", slot_ok[1], slot_dout[15:8], stray); end
        slot_cs = '0;
    endtask

    task automatic test_fixed_priority();
        int order [3] = '{0, 2, 3};
        logic [19:0] a [SLOTS];
        logic [21:0] ga; logic got; int w;
        pulse_flush();
        for (int s = 0; s < SLOTS; s++) begin
            a[s] = rand_addr();
            slot_addr[s*SLOT_AW +: SLOT_AW] = a[s];
        end
        slot_cs = 4'b1101;
        for (int k = 0; k < 3; k++) begin
            serve1(1'b0, ga, got, w);
            checks++; if (got !== 1'b1 || ga !== exp_addr(order[k], a[order[k]])) begin fails++; $display("FAIL prio_grant%0d got=%b/%h exp=1/%h", k, got, ga, exp_addr(order[k], a[order[k]])); end
            if (k > 0) begin
                checks++; if (w !== 0) begin fails++; $display("FAIL prio_b2b%0d got=%0d exp=0", k, w); end
            end
            checks++; if (slot_ok[order[k]] !== 1'b1 || slot_dout[order[k]*8 +: 8] !== exp_byte(order[k], a[order[k]])) begin fails++; $display("FAIL prio_data%0d got=%b/%h exp=1/%h", k, slot_ok[order[k]], slot_dout[order[k]*8 +: 8], exp_byte(order[k], a[order[k]])); end
        end
        tick();
        checks++; if (sdram_req !== 1'b0) begin fails++; $display("FAIL prio_idle got=%b exp=0", sdram_req); end
        slot_cs = '0;
    endtask

    task automatic test_flush_data();
        logic [19:0] a;
        logic [21:0] ga; logic got; int w;
        pulse_flush();
        a = rand_addr();
        slot_addr[2*SLOT_AW +: SLOT_AW] = a;
        slot_cs = 4'b0100;
        serve1(1'b1, ga, got, w);
        checks++; if (got !== 1'b1 || ga !== exp_addr(2, a)) begin fails++; $display("FAIL flush_req got=%b/%h exp=1/%h", got, ga, exp_addr(2, a)); end
        checks++; if (slot_ok[2] !== 1'b0) begin fails++; $display("FAIL flush_ok got=%b exp=0", slot_ok[2]); end
        serve1(1'b0, ga, got, w);
        checks++; if (got !== 1'b1 || ga !== exp_addr(2, a) || w > 3) begin fails++; $display("FAIL flush_rereq got=%b/%h/%0d exp=1/%h/<=3", got, ga, w, exp_addr(2, a)); end
        checks++; if (slot_ok[2] !== 1'b1 || slot_dout[23:16] !== exp_byte(2, a)) begin fails++; $display("FAIL flush_refill got=%b/%h exp=1/%h", slot_ok[2], slot_dout[23:16], exp_byte(2, a)); end
        slot_cs = '0;
    endtask

    task automatic test_refresh();
        logic [21:0] ga; logic got; int w;
        pulse_flush();
        vblank = 1'b1;
        tick();
        checks++; if (refresh_en !== 1'b1) begin fails++; $display("FAIL refresh_on got=%b exp=1", refresh_en); end
        vblank = 1'b0;
        tick();
        checks++; if (refresh_en !== 1'b0) begin fails++; $display("FAIL refresh_novb got=%b exp=0", refresh_en); end
        vblank = 1'b1;
        tick();
        slot_addr[0 +: SLOT_AW] = rand_addr();
        slot_cs = 4'b0001;
        tick();
        checks++; if (sdram_req !== 1'b1 || refresh_en !== 1'b0) begin fails++; $display("FAIL refresh_miss got=%b/%b exp=1/0", sdram_req, refresh_en); end
        serve1(1'b0, ga, got, w);
        slot_cs = '0;
        vblank = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        logic [19:0] a;
        logic [21:0] ga; logic got; int w;
        pulse_flush();
        a = rand_addr();
        slot_addr[3*SLOT_AW +: SLOT_AW] = a;
        slot_cs = 4'b1000;
        tick();
        sdram_ack = 1'b1;
        rst_n = 1'b0;
        #1;
        checks++; if (sdram_req !== 1'b0 || ready !== 1'b0) begin fails++; $display("FAIL rstmid_async got=%b/%b exp=0/0", sdram_req, ready); end
        sdram_ack = 1'b0;
        slot_cs = '0;
        tick();
        rst_n = 1'b1;
        data_rdy = 1'b1; data_read = $urandom;
        tick();
        data_rdy = 1'b0;
        slot_cs = 4'b1000;
        #1;
        checks++; if (slot_ok[3] !== 1'b0) begin fails++; $display("FAIL rstmid_late got=%b exp=0", slot_ok[3]); end
        serve1(1'b0, ga, got, w);
        checks++; if (got !== 1'b1 || ga !== exp_addr(3, a)) begin fails++; $display("FAIL rstmid_rereq got=%b/%h exp=1/%h", got, ga, exp_addr(3, a)); end
        slot_cs = '0;
        repeat (4) tick();
    endtask

    task automatic test_round_robin();
        logic [19:0] a [SLOTS];
        int ptr, prev, g, e, n;
        logic fnd;
        pulse_flush();
        for (int s = 0; s < SLOTS; s++) begin
            a[s] = rand_addr();
            addr2[s*SLOT_AW +: SLOT_AW] = a[s];
        end
        cs2 = 4'b1001;
        ptr = 0; prev = -1;
        for (int k = 0; k < 6; k++) begin
            n = 0;
            while (!req2 && n < 10) begin
                tick();
                n++;
            end
            checks++; if (req2 !== 1'b1) begin fails++; $display("FAIL rr_timeout%0d got=%b exp=1", k, req2); break; end
            g = int'(saddr2[21:16]);
            e = 0; fnd = 1'b0;
            for (int j = 0; j < SLOTS; j++) begin
                int c;
                c = (ptr + j) % SLOTS;
                if (!fnd && cs2[c] && c != prev) begin e = c; fnd = 1'b1; end
            end
            checks++; if (g !== e || saddr2 !== exp_addr(e, a[e])) begin fails++; $display("FAIL rr_grant%0d got=%0d/%h exp=%0d/%h", k, g, saddr2, e, exp_addr(e, a[e])); end
            if (k > 0) begin
                checks++; if (n !== 0) begin fails++; $display("FAIL rr_b2b%0d got=%0d exp=0", k, n); end
            end
            ack2 = 1'b1;
            tick();
            ack2 = 1'b0;
            rdy2 = 1'b1; dread2 = $urandom; flush = 1'b1;
            tick();
            rdy2 = 1'b0; flush = 1'b0;
            checks++; if (ok2[g % SLOTS] !== 1'b0) begin fails++; $display("FAIL rr_flushed%0d got=%b exp=0", k, ok2[g % SLOTS]); end
            prev = g;
            ptr = (g + 1) % SLOTS;
        end
        cs2 = '0;
        n = 0;
        while (!req2 && n < 10) begin
            tick();
            n++;
        end
        ack2 = 1'b1;
        tick();
        ack2 = 1'b0;
        rdy2 = 1'b1;
        tick();
        rdy2 = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic [19:0] a [SLOTS];
        logic [3:0] csr;
        int pend [$];
        logic [21:0] ga; logic got; int w, p;
        pulse_flush();
        for (int r = 0; r < 20; r++) begin
            csr = 4'($urandom_range(1, 15));
            pend.delete();
            for (int s = 0; s < SLOTS; s++) begin
                if (mvalid[s] && $urandom_range(0, 1) == 1) a[s] = {mline[s], 2'($urandom_range(0, 3))};
                else a[s] = rand_addr();
                slot_addr[s*SLOT_AW +: SLOT_AW] = a[s];
                if (csr[s] && !(mvalid[s] && mline[s] == 18'(a[s] >> 2))) pend.push_back(s);
            end
            slot_cs = csr;
            while (pend.size() > 0) begin
                p = pend.pop_front();
                serve1(1'b0, ga, got, w);
                checks++; if (got !== 1'b1 || ga !== exp_addr(p, a[p])) begin fails++; $display("FAIL rand_req r%0d got=%b/%h exp=1/%h", r, got, ga, exp_addr(p, a[p])); end
            end
            tick();
            checks++; if (sdram_req !== 1'b0) begin fails++; $display("FAIL rand_extra r%0d got=%b exp=0", r, sdram_req); end
            for (int s = 0; s < SLOTS; s++) begin
                if (csr[s]) begin
                    checks++; if (slot_ok[s] !== 1'b1 || slot_dout[s*8 +: 8] !== exp_byte(s, a[s])) begin fails++; $display("FAIL rand_data r%0d s%0d got=%b/%h exp=1/%h", r, s, slot_ok[s], slot_dout[s*8 +: 8], exp_byte(s, a[s])); end
                    mvalid[s] = 1'b1;
                    mline[s]  = 18'(a[s] >> 2);
                end
            end
            slot_cs = '0;
            if ($urandom_range(0, 4) == 0) pulse_flush();
        end
    endtask

    initial begin
        for (int s = 0; s < SLOTS; s++) begin mvalid[s] = 1'b0; mline[s] = 18'd0; end
        test_reset();
        test_fill();
        test_fixed_priority();
        test_flush_data();
        test_refresh();
        test_reset_mid();
        test_round_robin();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
